// File: rtl/via_pkg.sv
//==============================================================================
// Module : via_pkg
// Brief  : Register map and bit indices shared by the 6522 VIA model.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package via_pkg;

    localparam logic [3:0] VIA_ORB    = 4'h0;
    localparam logic [3:0] VIA_ORA    = 4'h1;
    localparam logic [3:0] VIA_DDRB   = 4'h2;
    localparam logic [3:0] VIA_DDRA   = 4'h3;
    localparam logic [3:0] VIA_T1CL   = 4'h4;
    localparam logic [3:0] VIA_T1CH   = 4'h5;
    localparam logic [3:0] VIA_T1LL   = 4'h6;
    localparam logic [3:0] VIA_T1LH   = 4'h7;
    localparam logic [3:0] VIA_T2CL   = 4'h8;
    localparam logic [3:0] VIA_T2CH   = 4'h9;
    localparam logic [3:0] VIA_SR     = 4'hA;
    localparam logic [3:0] VIA_ACR    = 4'hB;
    localparam logic [3:0] VIA_PCR    = 4'hC;
    localparam logic [3:0] VIA_IFR    = 4'hD;
    localparam logic [3:0] VIA_IER    = 4'hE;
    localparam logic [3:0] VIA_ORA_NH = 4'hF;

    localparam int IFR_T1  = 6;
    localparam int IFR_T2  = 5;
    localparam int IFR_CB1 = 4;
    localparam int IFR_CA1 = 1;

    localparam int ACR_PB7     = 7;
    localparam int ACR_T1_FREE = 6;

endpackage

`default_nettype wire

// File: rtl/via_timer.sv
//==============================================================================
// Module : via_timer
// Brief  : 16-bit VIA interval counter with load, arm, underflow and reload.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module via_timer #(
    parameter logic [15:0] T_RESET = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [15:0] i_load_val,
    input  logic        i_free_run,
    input  logic [15:0] i_reload_val,
    output logic [15:0] o_count,
    output logic        o_underflow
);

    logic [15:0] r_count;
    logic        r_armed;
    logic        w_zero;

    assign w_zero      = (r_count == 16'h0000);
    // A load in the zero cycle takes priority and suppresses the event.
    assign o_underflow = w_zero & r_armed & ~i_load;
    assign o_count     = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= T_RESET;
            r_armed <= 1'b0;
        end else if (i_load) begin
            r_count <= i_load_val;
            r_armed <= 1'b1;
        end else if (w_zero) begin
            if (i_free_run) begin
                r_count <= i_reload_val;
            end else begin
                r_count <= 16'hFFFF;
                r_armed <= 1'b0;
            end
        end else begin
            r_count <= r_count - 16'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/via6522.sv
//==============================================================================
// Module : via6522
// Brief  : 6522 VIA: ports A/B with DDRs, timers T1/T2, IFR/IER and irq_n.
//          Define VIA_CA_CB_EN to add the CA1/CB1 edge-interrupt inputs.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module via6522 import via_pkg::*; #(
    parameter int          PA_WIDTH = 8,
    parameter int          PB_WIDTH = 8,
    parameter logic [15:0] T_RESET  = 16'hFFFF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                rnw,
    input  logic [3:0]          addr,
    input  logic [7:0]          din,
    output logic [7:0]          dout,
    input  logic [PA_WIDTH-1:0] pa_in,
    output logic [PA_WIDTH-1:0] pa_out,
    output logic [PA_WIDTH-1:0] pa_oe,
    input  logic [PB_WIDTH-1:0] pb_in,
    output logic [PB_WIDTH-1:0] pb_out,
    output logic [PB_WIDTH-1:0] pb_oe,
    output logic                irq_n
`ifdef VIA_CA_CB_EN
    ,
    input  logic                ca1,
    input  logic                cb1
`endif
);

    logic [PA_WIDTH-1:0] r_ora, r_ddra;
    logic [PB_WIDTH-1:0] r_orb, r_ddrb;
    logic [7:0]          r_acr, r_pcr;
    logic [6:0]          r_ier;
    logic [7:0]          r_t1l_lo, r_t1l_hi, r_t2l_lo;
    logic                r_t1_flag, r_t2_flag, r_pb7;

    logic        w_wr, w_rd;
    logic        w_t1_uf, w_t2_uf, w_t1_clr, w_t2_clr;
    logic [15:0] w_t1_count, w_t2_count;
    logic        w_ca1_flag, w_cb1_flag;
    logic [6:0]  w_ifr;
    logic        w_irq;

    assign w_wr = enable & ~rnw;
    assign w_rd = enable &  rnw;

    assign w_t1_clr = (w_wr && (addr == VIA_T1CH || addr == VIA_T1LH))
                    || (w_rd && addr == VIA_T1CL)
                    || (w_wr && addr == VIA_IFR && din[IFR_T1]);
    assign w_t2_clr = (w_wr && addr == VIA_T2CH)
                    || (w_rd && addr == VIA_T2CL)
                    || (w_wr && addr == VIA_IFR && din[IFR_T2]);

    via_timer #(.T_RESET(T_RESET)) u_t1 (
        .clk          (clk),
        .rst          (reset),
        .i_load       (w_wr && addr == VIA_T1CH),
        .i_load_val   ({din, r_t1l_lo}),
        .i_free_run   (r_acr[ACR_T1_FREE]),
        .i_reload_val ({r_t1l_hi, r_t1l_lo}),
        .o_count      (w_t1_count),
        .o_underflow  (w_t1_uf)
    );

    via_timer #(.T_RESET(T_RESET)) u_t2 (
        .clk          (clk),
        .rst          (reset),
        .i_load       (w_wr && addr == VIA_T2CH),
        .i_load_val   ({din, r_t2l_lo}),
        .i_free_run   (1'b0),
        .i_reload_val (16'h0000),
        .o_count      (w_t2_count),
        .o_underflow  (w_t2_uf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ora     <= '0;
            r_ddra    <= '0;
            r_orb     <= '0;
            r_ddrb    <= '0;
            r_acr     <= 8'h00;
            r_pcr     <= 8'h00;
            r_ier     <= 7'h00;
            r_t1l_lo  <= T_RESET[7:0];
            r_t1l_hi  <= T_RESET[15:8];
            r_t2l_lo  <= 8'h00;
            r_t1_flag <= 1'b0;
            r_t2_flag <= 1'b0;
            r_pb7     <= 1'b1;
        end else begin
            if (w_wr) begin
                case (addr)
                    VIA_ORB:              r_orb    <= din[PB_WIDTH-1:0];
                    VIA_ORA, VIA_ORA_NH:  r_ora    <= din[PA_WIDTH-1:0];
                    VIA_DDRB:             r_ddrb   <= din[PB_WIDTH-1:0];
                    VIA_DDRA:             r_ddra   <= din[PA_WIDTH-1:0];
                    VIA_T1CL, VIA_T1LL:   r_t1l_lo <= din;
                    VIA_T1CH, VIA_T1LH:   r_t1l_hi <= din;
                    VIA_T2CL:             r_t2l_lo <= din;
                    VIA_ACR:              r_acr    <= din;
                    VIA_PCR:              r_pcr    <= din;
                    VIA_IER:              r_ier    <= din[7] ? (r_ier | din[6:0])
                                                             : (r_ier & ~din[6:0]);
                    default: ;
                endcase
            end
            // A timer event in the same cycle as a clear leaves the flag set.
            r_t1_flag <= w_t1_uf | (r_t1_flag & ~w_t1_clr);
            r_t2_flag <= w_t2_uf | (r_t2_flag & ~w_t2_clr);
            if (w_wr && addr == VIA_T1CH) begin
                r_pb7 <= 1'b0;
            end else if (w_t1_uf) begin
                r_pb7 <= ~r_pb7;
            end
        end
    end

`ifdef VIA_CA_CB_EN
    logic r_ca1_s, r_ca1_p, r_cb1_s, r_cb1_p, r_ca1_flag, r_cb1_flag;
    logic w_ca1_edge, w_cb1_edge, w_ca1_clr, w_cb1_clr;

    // PCR0 / PCR4 select the active edge: 1 = rising, 0 = falling.
    assign w_ca1_edge = r_pcr[0] ? (r_ca1_s & ~r_ca1_p) : (~r_ca1_s & r_ca1_p);
    assign w_cb1_edge = r_pcr[4] ? (r_cb1_s & ~r_cb1_p) : (~r_cb1_s & r_cb1_p);
    assign w_ca1_clr  = (enable && addr == VIA_ORA)
                      || (w_wr && addr == VIA_IFR && din[IFR_CA1]);
    assign w_cb1_clr  = (enable && addr == VIA_ORB)
                      || (w_wr && addr == VIA_IFR && din[IFR_CB1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ca1_s    <= ca1;
            r_ca1_p    <= ca1;
            r_cb1_s    <= cb1;
            r_cb1_p    <= cb1;
            r_ca1_flag <= 1'b0;
            r_cb1_flag <= 1'b0;
        end else begin
            r_ca1_s    <= ca1;
            r_ca1_p    <= r_ca1_s;
            r_cb1_s    <= cb1;
            r_cb1_p    <= r_cb1_s;
            r_ca1_flag <= w_ca1_edge | (r_ca1_flag & ~w_ca1_clr);
            r_cb1_flag <= w_cb1_edge | (r_cb1_flag & ~w_cb1_clr);
        end
    end

    assign w_ca1_flag = r_ca1_flag;
    assign w_cb1_flag = r_cb1_flag;
`else
    assign w_ca1_flag = 1'b0;
    assign w_cb1_flag = 1'b0;
`endif

    always_comb begin
        w_ifr          = 7'h00;
        w_ifr[IFR_T1]  = r_t1_flag;
        w_ifr[IFR_T2]  = r_t2_flag;
        w_ifr[IFR_CB1] = w_cb1_flag;
        w_ifr[IFR_CA1] = w_ca1_flag;
    end

    assign w_irq = |(w_ifr & r_ier);
    assign irq_n = ~w_irq;

    assign pa_out = r_ora;
    assign pa_oe  = r_ddra;

    generate
        if (PB_WIDTH == 8) begin : g_pb7_timer
            assign pb_out = {r_acr[ACR_PB7] ? r_pb7 : r_orb[7], r_orb[6:0]};
            assign pb_oe  = {r_acr[ACR_PB7] | r_ddrb[7], r_ddrb[6:0]};
        end else begin : g_pb_plain
            assign pb_out = r_orb;
            assign pb_oe  = r_ddrb;
        end
    endgenerate

    always_comb begin
        dout = 8'h00;
        case (addr)
            VIA_ORB:             dout[PB_WIDTH-1:0] = (r_orb & r_ddrb) | (pb_in & ~r_ddrb);
            VIA_ORA, VIA_ORA_NH: dout[PA_WIDTH-1:0] = (r_ora & r_ddra) | (pa_in & ~r_ddra);
            VIA_DDRB:            dout[PB_WIDTH-1:0] = r_ddrb;
            VIA_DDRA:            dout[PA_WIDTH-1:0] = r_ddra;
            VIA_T1CL:            dout = w_t1_count[7:0];
            VIA_T1CH:            dout = w_t1_count[15:8];
            VIA_T1LL:            dout = r_t1l_lo;
            VIA_T1LH:            dout = r_t1l_hi;
            VIA_T2CL:            dout = w_t2_count[7:0];
            VIA_T2CH:            dout = w_t2_count[15:8];
            VIA_SR:              dout = 8'h00;
            VIA_ACR:             dout = r_acr;
            VIA_PCR:             dout = r_pcr;
            VIA_IFR:             dout = {w_irq, w_ifr};
            VIA_IER:             dout = {1'b1, r_ier};
            default:             dout = 8'h00;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_via6522.sv
//==============================================================================
// Module : tb_via6522
// Brief  : Self-checking bench for via6522 with a cycle-arithmetic timer model.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_via6522;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       rnw = 1'b1;
    logic [3:0] addr = 4'h0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic [7:0] pa_in = 8'h00, pa_out, pa_oe;
    logic [7:0] pb_in = 8'h00, pb_out, pb_oe;
    logic       irq_n;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    via6522 dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .rnw    (rnw),
        .addr   (addr),
        .din    (din),
        .dout   (dout),
        .pa_in  (pa_in),
        .pa_out (pa_out),
        .pa_oe  (pa_oe),
        .pb_in  (pb_in),
        .pb_out (pb_out),
        .pb_oe  (pb_oe),
        .irq_n  (irq_n)
    );

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        enable = 1'b1; rnw = 1'b0; addr = a; din = d;
        @(posedge clk);
        #1 enable = 1'b0; rnw = 1'b1;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk);
        enable = 1'b1; rnw = 1'b1; addr = a;
        #1 d = dout;
        @(posedge clk);
        #1 enable = 1'b0;
    endtask

    // Side-effect-free look at a register (enable low), used mid-window.
    task automatic peek(input logic [3:0] a, output logic [7:0] d);
        addr = a;
        #1 d = dout;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] lo, hi, v;
        do_reset();
        peek(4'h4, lo); peek(4'h5, hi);
        total_cnt++; if ({hi, lo} !== 16'hFFFF) $display("FAIL reset_t1: got %h want FFFF", {hi, lo}); else pass_cnt++;
        peek(4'h6, lo); peek(4'h7, hi);
        total_cnt++; if ({hi, lo} !== 16'hFFFF) $display("FAIL reset_t1l: got %h want FFFF", {hi, lo}); else pass_cnt++;
        total_cnt++; if (irq_n !== 1'b1) $display("FAIL reset_irq: got %b want 1", irq_n); else pass_cnt++;
        rd(4'hD, v);
        total_cnt++; if (v !== 8'h00) $display("FAIL reset_ifr: got %h want 00", v); else pass_cnt++;
        rd(4'hE, v);
        total_cnt++; if (v !== 8'h80) $display("FAIL reset_ier: got %h want 80", v); else pass_cnt++;
        rd(4'h2, v);
        total_cnt++; if (v !== 8'h00) $display("FAIL reset_ddrb: got %h want 00", v); else pass_cnt++;
        rd(4'h3, v);
        total_cnt++; if (v !== 8'h00) $display("FAIL reset_ddra: got %h want 00", v); else pass_cnt++;
    endtask

    task automatic test_ports();
        logic [7:0] ddr, orr, pin, v, e;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin ddr = 8'hF0; orr = 8'hA5; pin = 8'h3C; end
            else begin ddr = 8'($urandom); orr = 8'($urandom); pin = 8'($urandom); end
            e = (orr & ddr) | (pin & ~ddr);
            wr(4'h3, ddr); wr(4'h1, orr); pa_in = pin;
            rd(4'h1, v);
            total_cnt++; if (v !== e) $display("FAIL port_a_read: got %h want %h", v, e); else pass_cnt++;
            rd(4'hF, v);
            total_cnt++; if (v !== e) $display("FAIL port_a_nh_read: got %h want %h", v, e); else pass_cnt++;
            total_cnt++; if (pa_oe !== ddr || pa_out !== orr) $display("FAIL port_a_pins: got %h/%h want %h/%h", pa_oe, pa_out, ddr, orr); else pass_cnt++;
            wr(4'h2, ~ddr); wr(4'h0, orr ^ 8'h5A); pb_in = ~pin;
            e = ((orr ^ 8'h5A) & ~ddr) | (~pin & ddr);
            rd(4'h0, v);
            total_cnt++; if (v !== e) $display("FAIL port_b_read: got %h want %h", v, e); else pass_cnt++;
            total_cnt++; if (pb_oe !== ~ddr || pb_out !== (orr ^ 8'h5A)) $display("FAIL port_b_pins: got %h/%h want %h/%h", pb_oe, pb_out, ~ddr, orr ^ 8'h5A); else pass_cnt++;
        end
    endtask

    task automatic test_ier();
        logic [6:0] m;
        logic [7:0] w, v;
        do_reset();
        m = 7'h00;
        for (int i = 0; i < 8; i++) begin
            w = 8'($urandom);
            wr(4'hE, w);
            m = w[7] ? (m | w[6:0]) : (m & ~w[6:0]);
            rd(4'hE, v);
            total_cnt++; if (v !== {1'b1, m}) $display("FAIL ier_rw: got %h want %h", v, {1'b1, m}); else pass_cnt++;
        end
    endtask

    task automatic test_t1_oneshot();
        int n;
        logic [7:0] lo, hi, f, v;
        logic [15:0] e;
        for (int it = 0; it < 2; it++) begin
            n = (it == 0) ? 3 : int'($urandom_range(20, 2));
            do_reset();
            wr(4'hE, 8'hC0); wr(4'h6, 8'(n)); wr(4'h5, 8'h00);
            for (int j = 0; j <= n + 3; j++) begin
                @(negedge clk);
                peek(4'h4, lo); peek(4'h5, hi); peek(4'hD, f);
                e = 16'(n - j);
                total_cnt++; if ({hi, lo} !== e) $display("FAIL t1_count j=%0d: got %h want %h", j, {hi, lo}, e); else pass_cnt++;
                total_cnt++; if (f !== ((j >= n + 1) ? 8'hC0 : 8'h00)) $display("FAIL t1_flag j=%0d: got %h", j, f); else pass_cnt++;
                total_cnt++; if (irq_n !== (j < n + 1)) $display("FAIL t1_irq j=%0d: got %b", j, irq_n); else pass_cnt++;
            end
            rd(4'h4, v);
            e = 16'(n - (n + 4));
            total_cnt++; if (v !== e[7:0]) $display("FAIL t1_read_lo: got %h want %h", v, e[7:0]); else pass_cnt++;
            @(negedge clk); peek(4'hD, f);
            total_cnt++; if (f !== 8'h00 || irq_n !== 1'b1) $display("FAIL t1_clear: got %h/%b want 00/1", f, irq_n); else pass_cnt++;
            idle(40); peek(4'hD, f);
            total_cnt++; if (f !== 8'h00) $display("FAIL t1_no_refire: got %h want 00", f); else pass_cnt++;
        end
    endtask

    task automatic test_t1_freerun();
        int n;
        logic [7:0] lo, hi, f;
        logic [15:0] e;
        n = int'($urandom_range(8, 2));
        do_reset();
        wr(4'hE, 8'hC0); wr(4'hB, 8'hC0); wr(4'h6, 8'(n)); wr(4'h7, 8'h00); wr(4'h5, 8'h00);
        for (int j = 0; j <= 3 * (n + 1) + 1; j++) begin
            @(negedge clk);
            peek(4'h4, lo); peek(4'h5, hi); peek(4'hD, f);
            e = 16'(n - (j % (n + 1)));
            total_cnt++; if ({hi, lo} !== e) $display("FAIL t1f_count j=%0d: got %h want %h", j, {hi, lo}, e); else pass_cnt++;
            total_cnt++; if (f !== ((j >= n + 1) ? 8'hC0 : 8'h00)) $display("FAIL t1f_flag j=%0d: got %h", j, f); else pass_cnt++;
            total_cnt++; if (pb_out[7] !== 1'((j / (n + 1)) % 2)) $display("FAIL t1f_pb7 j=%0d: got %b", j, pb_out[7]); else pass_cnt++;
            total_cnt++; if (pb_oe[7] !== 1'b1) $display("FAIL t1f_pb7_oe: got %b want 1", pb_oe[7]); else pass_cnt++;
        end
    endtask

    task automatic test_t2();
        int l;
        logic [7:0] lo, hi, f, v;
        logic [15:0] e;
        l = int'($urandom_range(20, 2));
        do_reset();
        wr(4'hE, 8'hA0); wr(4'h8, 8'(l)); wr(4'h9, 8'h00);
        for (int j = 0; j <= l + 3; j++) begin
            @(negedge clk);
            peek(4'h8, lo); peek(4'h9, hi); peek(4'hD, f);
            e = 16'(l - j);
            total_cnt++; if ({hi, lo} !== e) $display("FAIL t2_count j=%0d: got %h want %h", j, {hi, lo}, e); else pass_cnt++;
            total_cnt++; if (f !== ((j >= l + 1) ? 8'hA0 : 8'h00)) $display("FAIL t2_flag j=%0d: got %h", j, f); else pass_cnt++;
        end
        wr(4'hE, 8'h20);
        @(negedge clk); peek(4'hD, f);
        total_cnt++; if (f !== 8'h20 || irq_n !== 1'b1) $display("FAIL t2_masked: got %h/%b want 20/1", f, irq_n); else pass_cnt++;
        wr(4'hE, 8'hA0);
        rd(4'h8, v);
        @(negedge clk); peek(4'hD, f);
        total_cnt++; if (f !== 8'h00 || irq_n !== 1'b1) $display("FAIL t2_clear: got %h/%b want 00/1", f, irq_n); else pass_cnt++;
        idle(66000); peek(4'hD, f);
        total_cnt++; if (f !== 8'h00 || irq_n !== 1'b1) $display("FAIL t2_no_refire: got %h/%b want 00/1", f, irq_n); else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        int n;
        logic [7:0] lo, hi, f, v;
        logic [15:0] e;
        n = int'($urandom_range(10, 2));
        do_reset();
        wr(4'hE, 8'hC0); wr(4'h6, 8'(n)); wr(4'h5, 8'h00);
        idle(n); wr(4'h5, 8'h00);
        for (int j = 0; j <= n + 2; j++) begin
            @(negedge clk);
            peek(4'h4, lo); peek(4'h5, hi); peek(4'hD, f);
            e = 16'(n - j);
            total_cnt++; if ({hi, lo} !== e) $display("FAIL sim_reload j=%0d: got %h want %h", j, {hi, lo}, e); else pass_cnt++;
            total_cnt++; if (f !== ((j >= n + 1) ? 8'hC0 : 8'h00)) $display("FAIL sim_reload_flag j=%0d: got %h", j, f); else pass_cnt++;
        end
        wr(4'h5, 8'h00); idle(n); rd(4'h4, v);
        total_cnt++; if (v !== 8'h00) $display("FAIL sim_read_lo: got %h want 00", v); else pass_cnt++;
        @(negedge clk); peek(4'hD, f);
        total_cnt++; if (f !== 8'hC0) $display("FAIL sim_read_vs_set: got %h want C0", f); else pass_cnt++;
        wr(4'h5, 8'h00); idle(n); wr(4'hD, 8'h40);
        @(negedge clk); peek(4'hD, f);
        total_cnt++; if (f !== 8'hC0) $display("FAIL sim_ifrw_vs_set: got %h want C0", f); else pass_cnt++;
        wr(4'hD, 8'h40);
        @(negedge clk); peek(4'hD, f);
        total_cnt++; if (f !== 8'h00) $display("FAIL sim_ifr_clear: got %h want 00", f); else pass_cnt++;
    endtask

    task automatic test_reset_midcount();
        int n;
        logic [7:0] lo, hi, f;
        n = int'($urandom_range(10, 3));
        do_reset();
        wr(4'hE, 8'hE0); wr(4'h6, 8'(n)); wr(4'h5, 8'h00); wr(4'h8, 8'(n)); wr(4'h9, 8'h00);
        idle(1);
        do_reset();
        peek(4'h4, lo); peek(4'h5, hi);
        total_cnt++; if ({hi, lo} !== 16'hFFFF) $display("FAIL midrst_t1: got %h want FFFF", {hi, lo}); else pass_cnt++;
        peek(4'h8, lo); peek(4'h9, hi);
        total_cnt++; if ({hi, lo} !== 16'hFFFF) $display("FAIL midrst_t2: got %h want FFFF", {hi, lo}); else pass_cnt++;
        wr(4'hE, 8'hE0);
        idle(n + 6); peek(4'hD, f);
        total_cnt++; if (f !== 8'h00 || irq_n !== 1'b1) $display("FAIL midrst_flag: got %h/%b want 00/1", f, irq_n); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_ports();
        test_ier();
        test_t1_oneshot();
        test_t1_freerun();
        test_simultaneous();
        test_reset_midcount();
        test_t2();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
